// File: rtl/conv_pass_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_pass_sched
// Purpose  : Sequences a full convolution layer on accelerator_core as a
//            series of passes. Channel groups form the inner loop and kernel
//            groups the outer loop. For every pass the block presents data,
//            weight and psum BRAM base addresses plus a psum-accumulate flag,
//            pulses the core start and waits for the core done pulse.
// Ports    :
//   clk, rst           - system clock, synchronous active-high reset
//   i_start            - one-cycle layer start (accepted only in IDLE)
//   i_abort            - return to IDLE from any busy state, clears outputs
//   i_num_kgrp/cgrp    - kernel / channel group counts (latched on start)
//   i_*_stride         - base address increments (latched on start)
//   i_core_done        - one-cycle pass-complete pulse from the core
//   o_core_start       - one-cycle pass start pulse to the core
//   o_data/weight/psum_base - BRAM bases for the current pass
//   o_psum_acc         - 1 = accumulate into psum, 0 = overwrite
//   o_kgrp, o_cgrp     - current group indices
//   o_busy, o_done     - busy level, one-cycle layer-complete pulse
// Revision : 1.0 - initial release
// ============================================================================
module conv_pass_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CNT_WIDTH-1:0]  i_num_kgrp,
  input  logic [CNT_WIDTH-1:0]  i_num_cgrp,
  input  logic [ADDR_WIDTH-1:0] i_data_stride,
  input  logic [ADDR_WIDTH-1:0] i_weight_stride,
  input  logic [ADDR_WIDTH-1:0] i_psum_stride,
  input  logic                  i_core_done,
  output logic                  o_core_start,
  output logic [ADDR_WIDTH-1:0] o_data_base,
  output logic [ADDR_WIDTH-1:0] o_weight_base,
  output logic [ADDR_WIDTH-1:0] o_psum_base,
  output logic                  o_psum_acc,
  output logic [CNT_WIDTH-1:0]  o_kgrp,
  output logic [CNT_WIDTH-1:0]  o_cgrp,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  C_CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] C_ADR_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched layer configuration
  logic [CNT_WIDTH-1:0]  r_num_kgrp;
  logic [CNT_WIDTH-1:0]  r_num_cgrp;
  logic [ADDR_WIDTH-1:0] r_data_stride;
  logic [ADDR_WIDTH-1:0] r_weight_stride;
  logic [ADDR_WIDTH-1:0] r_psum_stride;

  // Per-pass state
  logic [CNT_WIDTH-1:0]  r_kgrp;
  logic [CNT_WIDTH-1:0]  r_cgrp;
  logic [ADDR_WIDTH-1:0] r_data_base;
  logic [ADDR_WIDTH-1:0] r_weight_base;
  logic [ADDR_WIDTH-1:0] r_psum_base;
  logic                  r_psum_acc;

  logic w_accept;      // start accepted this cycle
  logic w_kill;        // abort while busy: wipe everything back to reset values
  logic w_zero_layer;  // requested layer has no passes at all
  logic w_more_cgrp;
  logic w_more_kgrp;

  assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_kill       = i_abort && (r_state != S_IDLE);
  assign w_zero_layer = (i_num_kgrp == C_CNT_ZERO) || (i_num_cgrp == C_CNT_ZERO);

  // Counts are at least one whenever a pass is running, so the subtraction
  // cannot underflow where these are consumed.
  assign w_more_cgrp  = (r_cgrp < (r_num_cgrp - C_CNT_ONE));
  assign w_more_kgrp  = (r_kgrp < (r_num_kgrp - C_CNT_ONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_layer ? S_DONE : S_START;
        end
      end
      // Done during START is ignored: the core cannot finish a pass it has
      // not yet seen started.
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_core_done) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_more_cgrp || w_more_kgrp) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_kill) begin
      w_state_nxt = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration latch, group counters and base address generation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_kill) begin
      r_num_kgrp      <= C_CNT_ZERO;
      r_num_cgrp      <= C_CNT_ZERO;
      r_data_stride   <= C_ADR_ZERO;
      r_weight_stride <= C_ADR_ZERO;
      r_psum_stride   <= C_ADR_ZERO;
      r_kgrp          <= C_CNT_ZERO;
      r_cgrp          <= C_CNT_ZERO;
      r_data_base     <= C_ADR_ZERO;
      r_weight_base   <= C_ADR_ZERO;
      r_psum_base     <= C_ADR_ZERO;
      r_psum_acc      <= 1'b0;
    end else if (w_accept) begin
      r_num_kgrp      <= i_num_kgrp;
      r_num_cgrp      <= i_num_cgrp;
      r_data_stride   <= i_data_stride;
      r_weight_stride <= i_weight_stride;
      r_psum_stride   <= i_psum_stride;
      r_kgrp          <= C_CNT_ZERO;
      r_cgrp          <= C_CNT_ZERO;
      r_data_base     <= C_ADR_ZERO;
      r_weight_base   <= C_ADR_ZERO;
      r_psum_base     <= C_ADR_ZERO;
      r_psum_acc      <= 1'b0;
    end else if (r_state == S_NEXT) begin
      if (w_more_cgrp) begin
        // Next channel group of the same kernel group: accumulate.
        r_cgrp        <= r_cgrp + C_CNT_ONE;
        r_data_base   <= r_data_base + r_data_stride;
        r_weight_base <= r_weight_base + r_weight_stride;
        r_psum_acc    <= 1'b1;
      end else if (w_more_kgrp) begin
        // New kernel group: restart the channel sweep, fresh psum region.
        r_cgrp        <= C_CNT_ZERO;
        r_kgrp        <= r_kgrp + C_CNT_ONE;
        r_data_base   <= C_ADR_ZERO;
        r_weight_base <= r_weight_base + r_weight_stride;
        r_psum_base   <= r_psum_base + r_psum_stride;
        r_psum_acc    <= 1'b0;
      end
      // Last pass: everything keeps its final-pass value.
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_core_start  = (r_state == S_START);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_data_base   = r_data_base;
  assign o_weight_base = r_weight_base;
  assign o_psum_base   = r_psum_base;
  assign o_psum_acc    = r_psum_acc;
  assign o_kgrp        = r_kgrp;
  assign o_cgrp        = r_cgrp;

endmodule
`default_nettype wire

// File: doc/conv_pass_sched.md
Name: conv_pass_sched

Overview:
- Sequences a full convolution layer on accelerator_core as a series of passes.
- Each pass covers NUM_KERNEL kernels × NUM_CHANNEL channels.
- Iterates channel groups (inner loop) within kernel groups (outer loop). Per pass it provides data, weight and psum BRAM base addresses plus a psum accumulate flag, pulses the core start, and waits for core done.
- Sits between the host config registers and accelerator_core, data_req and weight_req.

Parameters:
ADDR_WIDTH, 32, width of all BRAM base addresses and strides
CNT_WIDTH, 16, width of group counters and group-count inputs

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle layer start request; sampled only in IDLE
i_abort  input  1  abort current layer; any non-IDLE state returns to IDLE
i_num_kgrp  input  CNT_WIDTH  number of kernel groups; latched on accepted start
i_num_cgrp  input  CNT_WIDTH  number of channel groups; latched on accepted start
i_data_stride  input  ADDR_WIDTH  data base increment per channel group; latched
i_weight_stride  input  ADDR_WIDTH  weight base increment per pass; latched
i_psum_stride  input  ADDR_WIDTH  psum base increment per kernel group; latched
i_core_done  input  1  one-cycle pass-complete pulse from core
o_core_start  output  1  one-cycle pass start pulse to core
o_data_base  output  ADDR_WIDTH  data BRAM base for current pass
o_weight_base  output  ADDR_WIDTH  weight BRAM base for current pass
o_psum_base  output  ADDR_WIDTH  psum BRAM base for current pass
o_psum_acc  output  1  1 = accumulate into psum, 0 = overwrite (first channel group)
o_kgrp  output  CNT_WIDTH  current kernel-group index
o_cgrp  output  CNT_WIDTH  current channel-group index
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle layer-complete pulse

Behaviour:
- Reset (and abort) values: all outputs 0; state IDLE; latched config 0.
- States: IDLE, START, WAIT, NEXT, DONE.
- IDLE:
  - On i_start: latch all config inputs; clear kgrp, cgrp and all bases.
  - If latched i_num_kgrp==0 or i_num_cgrp==0: go to DONE. No core start is issued.
  - Otherwise go to START.
- START: o_core_start=1 for exactly this cycle, then WAIT.
- WAIT:
  - Hold all bases, indices and o_psum_acc stable.
  - On i_core_done go to NEXT.
- NEXT (one cycle), updates registered on exit:
  - If cgrp < num_cgrp-1: cgrp+1; data_base += data_stride; weight_base += weight_stride.
  - Else if kgrp < num_kgrp-1: cgrp=0; kgrp+1; data_base=0; weight_base += weight_stride; psum_base += psum_stride.
  - Else go to DONE with no update.
  - o_psum_acc = (new cgrp != 0).
  - Any non-DONE outcome goes to START.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - Bases and indices keep their last-pass values until the next accepted start.
- Bases, indices and o_psum_acc are valid from the START cycle through the end of WAIT.
- Latency:
  - Start accepted at cycle T gives o_core_start at T+1.
  - Done in WAIT at cycle N gives the next o_core_start at N+2, or o_done at N+2 after the last pass.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; wrap is silent.
- i_start while o_busy: ignored; latched config is unchanged.
- i_core_done outside WAIT: ignored.
- i_core_done in the START cycle: ignored; the core must not assert done before observing start.
- i_abort:
  - Highest priority over start and done in the same cycle.
  - From any non-IDLE state: next cycle IDLE, all outputs at reset values, no o_done pulse.
- rst mid-operation: identical effect to abort.
- Config input changes after start acceptance have no effect on the running layer.

Test Plan:
- Basic 2 passes:
  - Stimulus: kgrp=1, cgrp=2, data_stride=0x100, weight_stride=0x10, psum_stride=0x400; start; done 5 cycles after each core_start.
  - Required: exactly 2 core_start pulses. Pass 0: data 0x000, weight 0x00, psum 0, acc=0. Pass 1: data 0x100, weight 0x10, acc=1. o_done 2 cycles after second done.
- Kernel-group rollover:
  - Stimulus: kgrp=2, cgrp=3, same strides as above.
  - Required: 6 passes. Pass 3: kgrp=1, cgrp=0, data 0, weight 0x30, psum 0x400, acc=0. Pass 5: data 0x200, weight 0x50, acc=1. Single o_done.
- Zero groups:
  - Stimulus: kgrp=0, cgrp=4; start.
  - Required: no o_core_start. o_busy high for 1 cycle. o_done pulse at T+1.
- Abort:
  - Stimulus: i_abort in WAIT of pass 1 of a 2×2 layer.
  - Required: next cycle o_busy=0, all outputs 0, no o_done. A new start afterwards runs all 4 passes from index 0.
- Spurious inputs:
  - Stimulus: i_start pulsed during WAIT with different config; i_core_done pulsed in the START cycle and in IDLE.
  - Required: ignored. Pass sequence and count are unchanged.
- Reset mid-layer:
  - Stimulus: rst=1 for 1 cycle during NEXT.
  - Required: next cycle all outputs 0, state IDLE. Subsequent layer executes correctly.
